// File: rtl/rv32_shared_mem_responder_pkg.sv
// rtl/rv32_shared_mem_responder_pkg.sv - shared types for the instruction/data memory responder
//
// Purpose: FSM state, transaction owner and operation enums, plus the wait-counter width,
//          shared by the responder top and its arbiter.
// Ports:   none (package).
package rv32_mem_responder_pkg;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/rv32_shared_mem_responder_if.sv
// rtl/rv32_shared_mem_responder_if.sv - bundle of core-side and SRAM-side responder signals
//
// Purpose: groups the instruction port, data port and single-port SRAM port.
// Modports: slave  - the responder (takes requests and SRAM read data, drives readies and strobes).
//           master - the environment (core ports plus SRAM).
interface rv32_shared_mem_responder_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [31:0]           instr_address_in;
  logic                  instr_read_in;
  logic [31:0]           instr_read_value_out;
  logic                  instr_ready_out;
  logic [31:0]           data_address_in;
  logic                  data_read_in;
  logic                  data_write_in;
  logic [3:0]            data_write_mask_in;
  logic [31:0]           data_write_value_in;
  logic [31:0]           data_read_value_out;
  logic                  data_ready_out;
  logic [ADDR_WIDTH-1:0] sram_address_out;
  logic                  sram_read_out;
  logic                  sram_write_out;
  logic [3:0]            sram_write_mask_out;
  logic [31:0]           sram_write_value_out;
  logic [31:0]           sram_read_value_in;

  modport slave (
    input  instr_address_in, instr_read_in,
    output instr_read_value_out, instr_ready_out,
    input  data_address_in, data_read_in, data_write_in, data_write_mask_in, data_write_value_in,
    output data_read_value_out, data_ready_out,
    output sram_address_out, sram_read_out, sram_write_out, sram_write_mask_out, sram_write_value_out,
    input  sram_read_value_in
  );

  modport master (
    output instr_address_in, instr_read_in,
    input  instr_read_value_out, instr_ready_out,
    output data_address_in, data_read_in, data_write_in, data_write_mask_in, data_write_value_in,
    input  data_read_value_out, data_ready_out,
    input  sram_address_out, sram_read_out, sram_write_out, sram_write_mask_out, sram_write_value_out,
    output sram_read_value_in
  );
endinterface

// File: rtl/rv32_shared_mem_responder_arbiter.sv
// rtl/rv32_shared_mem_responder_arbiter.sv - two-way round-robin arbiter for the memory responder
//
// Purpose: picks one of the instruction/data requesters; on a tie the master not served last wins.
// Ports:   i_req_instr, i_req_data - pending requests
//          i_last_owner            - master served by the previous access
//          o_grant                 - one-hot grant, bit 0 = instruction, bit 1 = data
module rv32_mem_rr_arbiter
  import rv32_mem_responder_pkg::*;
(
  input  logic       i_req_instr,
  input  logic       i_req_data,
  input  owner_e     i_last_owner,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_req_instr && i_req_data) begin
      o_grant = (i_last_owner == OWNER_DATA) ? 2'b01 : 2'b10;
    end else if (i_req_instr) begin
      o_grant = 2'b01;
    end else if (i_req_data) begin
      o_grant = 2'b10;
    end
  end

endmodule

// File: rtl/rv32_shared_mem_responder.sv
// rtl/rv32_shared_mem_responder.sv - instruction/data bus responder over one single-port SRAM
//
// Purpose: arbitrates the instruction and data masters onto one SRAM with 1-cycle read latency,
//          inserts WAIT_STATES idle cycles, latches each transaction at grant and returns a
//          one-cycle ready pulse to the owning master.
// Ports:   clk   - rising-edge clock
//          reset - synchronous, active-high
//          bus   - slave modport: core instruction/data ports and SRAM port
module rv32_shared_mem_responder
  import rv32_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_STATES = 0,
  parameter int DATA_FIRST  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  rv32_shared_mem_responder_if.slave   bus
);

  state_e                r_state;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  owner_e                r_owner;
  owner_e                r_last_owner;
  op_e                   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_mask;
  logic [31:0]           r_wdata;
  logic                  r_sram_read;
  logic                  r_sram_write;
  logic                  r_instr_ready;
  logic                  r_data_ready;

  logic       w_data_req;
  logic [1:0] w_grant;
  op_e        w_grant_op;
  logic       w_unused;

  assign w_data_req = bus.data_read_in | bus.data_write_in;
  // Read and write together counts as a write.
  assign w_grant_op = (w_grant[1] && bus.data_write_in) ? OP_WRITE : OP_READ;

  // Address bits outside the word index are deliberately ignored (aliasing).
  assign w_unused = ^{bus.instr_address_in[31:ADDR_WIDTH+2], bus.instr_address_in[1:0],
                      bus.data_address_in[31:ADDR_WIDTH+2], bus.data_address_in[1:0]};

  rv32_mem_rr_arbiter u_arbiter (
    .i_req_instr  (bus.instr_read_in),
    .i_req_data   (w_data_req),
    .i_last_owner (r_last_owner),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_wait_cnt    <= '0;
      r_owner       <= OWNER_INSTR;
      // Pretending the other master was served last makes the preferred one win the first tie.
      r_last_owner  <= (DATA_FIRST != 0) ? OWNER_INSTR : OWNER_DATA;
      r_op          <= OP_READ;
      r_addr        <= '0;
      r_mask        <= '0;
      r_wdata       <= '0;
      r_sram_read   <= 1'b0;
      r_sram_write  <= 1'b0;
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
    end else begin
      r_sram_read   <= 1'b0;
      r_sram_write  <= 1'b0;
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_owner <= w_grant[1] ? OWNER_DATA : OWNER_INSTR;
            r_op    <= w_grant_op;
            r_addr  <= w_grant[1] ? bus.data_address_in[ADDR_WIDTH+1:2]
                                  : bus.instr_address_in[ADDR_WIDTH+1:2];
            r_mask  <= w_grant[1] ? bus.data_write_mask_in : 4'h0;
            r_wdata <= w_grant[1] ? bus.data_write_value_in : 32'h0;
            if (WAIT_STATES == 0) begin
              r_state      <= ISSUE;
              r_sram_read  <= (w_grant_op == OP_READ);
              r_sram_write <= (w_grant_op == OP_WRITE);
            end else begin
              r_state    <= WAIT;
              r_wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt - 1'b1;
          if (r_wait_cnt == WAIT_CNT_W'(1)) begin
            r_state      <= ISSUE;
            r_sram_read  <= (r_op == OP_READ);
            r_sram_write <= (r_op == OP_WRITE);
          end
        end
        ISSUE: begin
          r_state       <= RESP;
          r_instr_ready <= (r_owner == OWNER_INSTR);
          r_data_ready  <= (r_owner == OWNER_DATA);
        end
        RESP: begin
          r_last_owner <= r_owner;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sram_address_out     = r_addr;
  assign bus.sram_read_out        = r_sram_read;
  assign bus.sram_write_out       = r_sram_write;
  assign bus.sram_write_mask_out  = r_mask;
  assign bus.sram_write_value_out = r_wdata;
  assign bus.instr_ready_out      = r_instr_ready;
  assign bus.data_ready_out       = r_data_ready;

  // SRAM read data arrives in the RESP cycle, which is exactly the ready cycle.
  assign bus.instr_read_value_out = r_instr_ready ? bus.sram_read_value_in : 32'h0;
  assign bus.data_read_value_out  = (r_data_ready && r_op == OP_READ) ? bus.sram_read_value_in : 32'h0;

endmodule

// File: tb/tb_rv32_shared_mem_responder.sv
// tb/tb_rv32_shared_mem_responder.sv - directed self-checking bench for rv32_shared_mem_responder
module tb_rv32_shared_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  rv32_shared_mem_responder_if #(.ADDR_WIDTH(12)) b0 ();
  rv32_shared_mem_responder_if #(.ADDR_WIDTH(12)) b3 ();

  rv32_shared_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0), .DATA_FIRST(1)) u0 (
    .clk(clk), .reset(reset), .bus(b0)
  );
  rv32_shared_mem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3), .DATA_FIRST(1)) u3 (
    .clk(clk), .reset(reset), .bus(b3)
  );

  // Single-port SRAM models, 1-cycle read latency; junk on the read bus when not reading.
  logic [31:0] mem0 [0:4095];
  logic [31:0] mem3 [0:4095];

  always @(posedge clk) begin
    if (pl_en) mem0[pl_addr] <= pl_data;
    if (b0.sram_write_out)
      for (int i = 0; i < 4; i++)
        if (b0.sram_write_mask_out[i])
          mem0[b0.sram_address_out][8*i +: 8] <= b0.sram_write_value_out[8*i +: 8];
    b0.sram_read_value_in <= b0.sram_read_out ? mem0[b0.sram_address_out] : 32'hBADBAD00;
  end

  always @(posedge clk) begin
    if (pl_en) mem3[pl_addr] <= pl_data;
    if (b3.sram_write_out)
      for (int i = 0; i < 4; i++)
        if (b3.sram_write_mask_out[i])
          mem3[b3.sram_address_out][8*i +: 8] <= b3.sram_write_value_out[8*i +: 8];
    b3.sram_read_value_in <= b3.sram_read_out ? mem3[b3.sram_address_out] : 32'hBADBAD00;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b0.instr_read_in = 0; b0.instr_address_in = 0;
    b0.data_read_in = 0; b0.data_write_in = 0; b0.data_address_in = 0;
    b0.data_write_mask_in = 0; b0.data_write_value_in = 0;
    b3.instr_read_in = 0; b3.instr_address_in = 0;
    b3.data_read_in = 0; b3.data_write_in = 0; b3.data_address_in = 0;
    b3.data_write_mask_in = 0; b3.data_write_value_in = 0;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_en = 1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 0;
  endtask

  // One access on the zero-wait-state responder, starting in an IDLE cycle c0.
  task automatic access0(input string tag, input bit is_instr, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wval,
                         input logic [31:0] exp_rd, input logic [11:0] exp_wa, input bit withdraw);
    if (is_instr) begin
      b0.instr_read_in = 1; b0.instr_address_in = addr;
    end else begin
      b0.data_read_in = rd; b0.data_write_in = wr; b0.data_address_in = addr;
      b0.data_write_mask_in = mask; b0.data_write_value_in = wval;
    end
    check({tag, ":c0_strobes"}, {b0.sram_read_out, b0.sram_write_out}, 0);
    tick();
    if (withdraw) begin
      b0.data_write_in = 0; b0.data_read_in = 0; b0.data_address_in = 32'h100;
      b0.data_write_value_in = 32'h0;
    end
    check({tag, ":c1_sram_read"}, b0.sram_read_out, (is_instr || !wr) ? 1 : 0);
    check({tag, ":c1_sram_write"}, b0.sram_write_out, (!is_instr && wr) ? 1 : 0);
    check({tag, ":c1_sram_addr"}, b0.sram_address_out, exp_wa);
    if (!is_instr && wr) begin
      check({tag, ":c1_mask"}, b0.sram_write_mask_out, mask);
      check({tag, ":c1_wval"}, b0.sram_write_value_out, wval);
    end
    check({tag, ":c1_readies"}, {b0.instr_ready_out, b0.data_ready_out}, 0);
    tick();
    check({tag, ":c2_readies"}, {b0.instr_ready_out, b0.data_ready_out}, is_instr ? 2'b10 : 2'b01);
    check({tag, ":c2_ival"}, b0.instr_read_value_out, is_instr ? exp_rd : 32'h0);
    check({tag, ":c2_dval"}, b0.data_read_value_out, is_instr ? 32'h0 : exp_rd);
    check({tag, ":c2_strobes"}, {b0.sram_read_out, b0.sram_write_out}, 0);
    idle_all();
    tick();
    check({tag, ":c3_readies"}, {b0.instr_ready_out, b0.data_ready_out}, 0);
    check({tag, ":c3_ival"}, b0.instr_read_value_out, 0);
  endtask

  initial begin
    idle_all();
    reset = 1;
    tick();
    tick();
    preload(12'h010, 32'hDEADBEEF);
    preload(12'h020, 32'hAABBCCDD);
    check("rst:b0_out", {b0.instr_ready_out, b0.data_ready_out, b0.sram_read_out, b0.sram_write_out}, 0);
    check("rst:b0_addr", b0.sram_address_out, 0);
    check("rst:b0_vals", b0.instr_read_value_out | b0.data_read_value_out, 0);
    check("rst:b3_out", {b3.instr_ready_out, b3.data_ready_out, b3.sram_read_out, b3.sram_write_out}, 0);
    reset = 0;
    tick();

    // Contention: data wins first, then strict alternation, one access every 3 cycles.
    b0.instr_read_in = 1; b0.instr_address_in = 32'h40;
    b0.data_read_in = 1;  b0.data_address_in = 32'h80;
    for (int c = 0; c <= 20; c++) begin
      bit ed, ei;
      ed = (c % 3 == 2) && ((c / 3) % 2 == 0);
      ei = (c % 3 == 2) && ((c / 3) % 2 == 1);
      check($sformatf("cont:c%0d_readies", c), {b0.instr_ready_out, b0.data_ready_out}, {ei, ed});
      check($sformatf("cont:c%0d_sram_read", c), b0.sram_read_out, (c % 3 == 1) ? 1 : 0);
      if (ed) check($sformatf("cont:c%0d_dval", c), b0.data_read_value_out, 32'hAABBCCDD);
      if (ei) check($sformatf("cont:c%0d_ival", c), b0.instr_read_value_out, 32'hDEADBEEF);
      if (c == 20) idle_all();
      tick();
    end

    access0("fetch",    1, 1, 0, 32'h40,   4'h0,    32'h0,        32'hDEADBEEF, 12'h010, 0);
    access0("store",    0, 0, 1, 32'h80,   4'b0011, 32'h12345678, 32'h0,        12'h020, 0);
    access0("load",     0, 1, 0, 32'h80,   4'h0,    32'h0,        32'hAABB5678, 12'h020, 0);
    access0("rdwr",     0, 1, 1, 32'h84,   4'hF,    32'h0BADF00D, 32'h0,        12'h021, 0);
    access0("alias",    0, 1, 0, 32'h4086, 4'h0,    32'h0,        32'h0BADF00D, 12'h021, 0);
    access0("wdraw",    0, 0, 1, 32'h80,   4'hF,    32'hCAFEF00D, 32'h0,        12'h020, 1);
    access0("wdraw_rb", 0, 1, 0, 32'h80,   4'h0,    32'h0,        32'hCAFEF00D, 12'h020, 0);

    // Three wait states: strobe at c4, ready at c5.
    b3.data_read_in = 1; b3.data_address_in = 32'h40;
    for (int c = 0; c <= 6; c++) begin
      check($sformatf("ws3:c%0d_sram_read", c), b3.sram_read_out, (c == 4) ? 1 : 0);
      check($sformatf("ws3:c%0d_dready", c), b3.data_ready_out, (c == 5) ? 1 : 0);
      check($sformatf("ws3:c%0d_dval", c), b3.data_read_value_out, (c == 5) ? 32'hDEADBEEF : 32'h0);
      if (c == 5) idle_all();
      tick();
    end

    // Reset while in WAIT kills the access.
    b3.instr_read_in = 1; b3.instr_address_in = 32'h40;
    for (int c = 0; c <= 8; c++) begin
      check($sformatf("rstmid:c%0d_out", c),
            {b3.sram_read_out, b3.sram_write_out, b3.instr_ready_out, b3.data_ready_out}, 0);
      check($sformatf("rstmid:c%0d_ival", c), b3.instr_read_value_out, 0);
      if (c == 2) begin reset = 1; idle_all(); end
      if (c == 4) reset = 0;
      tick();
    end

    // Fresh fetch after reset release: nominal latency.
    b3.instr_read_in = 1; b3.instr_address_in = 32'h43;
    for (int c = 0; c <= 6; c++) begin
      check($sformatf("fresh:c%0d_sram_read", c), b3.sram_read_out, (c == 4) ? 1 : 0);
      check($sformatf("fresh:c%0d_iready", c), b3.instr_ready_out, (c == 5) ? 1 : 0);
      check($sformatf("fresh:c%0d_ival", c), b3.instr_read_value_out, (c == 5) ? 32'hDEADBEEF : 32'h0);
      if (c == 5) idle_all();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32_shared_mem_responder.md
Name: rv32_shared_mem_responder

Overview:
- Bus responder at the far end of the core's instruction and data ports.
- Serves both masters from one single-ported synchronous SRAM with a 1-cycle read latency.
- Produces the instr_ready/data_ready pulses that the pipeline stall logic waits on.
- Arbitrates between the two masters, inserts configurable wait states, and latches each transaction at grant so master-side changes cannot corrupt an access in flight.

Parameters:
- ADDR_WIDTH, 12, SRAM word-address bits (4096 words).
- WAIT_STATES, 0, extra idle cycles between grant and SRAM issue (0..15).
- DATA_FIRST, 1, which master wins a simultaneous request out of reset (1 = data).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- instr_address_in  in  32  byte address.
- instr_read_in  in  1  fetch request, held until ready.
- instr_read_value_out  out  32  fetched word, valid only in the ready cycle.
- instr_ready_out  out  1  one-cycle completion pulse.
- data_address_in  in  32  byte address.
- data_read_in  in  1  load request.
- data_write_in  in  1  store request.
- data_write_mask_in  in  4  byte enables.
- data_write_value_in  in  32  store data.
- data_read_value_out  out  32  load word, valid only in the ready cycle.
- data_ready_out  out  1  one-cycle completion pulse.
- sram_address_out  out  ADDR_WIDTH  word address.
- sram_read_out  out  1  read strobe.
- sram_write_out  out  1  write strobe.
- sram_write_mask_out  out  4  byte enables.
- sram_write_value_out  out  32  write data.
- sram_read_value_in  in  32  read data, valid the cycle after sram_read_out.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state IDLE, preference = DATA_FIRST.
  - All outputs 0 in the cycle after reset asserts and while it is held.
  - An SRAM strobe already issued before reset is not undone.
- Request: a master asserts read/write and holds it until it samples ready=1. Ready is a single-cycle pulse.
- Read values are combinational from sram_read_value_in, gated to the owner's ready cycle; they are 0 at all other times.
- Address: word address = address[ADDR_WIDTH+1:2]. Bits [1:0] and the upper bits are ignored (aliasing, no error).
- data_read_in and data_write_in both high: treated as a write; data_read_value_out stays 0.
- FSM states: IDLE, WAIT, ISSUE, RESP.
  - IDLE: with no request, stay. With one requester, grant it. With both, grant the master not served last; the preference register breaks the first tie.
  - IDLE grant: latch owner, word address, op, mask and write value. Go to WAIT with count = WAIT_STATES, or to ISSUE if WAIT_STATES = 0.
  - WAIT: decrement the count; at count == 1 go to ISSUE.
  - ISSUE: drive sram_address_out from the latch, plus exactly one strobe: sram_read_out, or sram_write_out with mask and value. Go to RESP.
  - RESP: pulse the owner's ready; for a read, drive the owner's read value. Update last-served to the owner, then go to IDLE.
- Latency: request first seen in IDLE at cycle t gives ready at t+2+WAIT_STATES. Minimum spacing between accesses is 3+WAIT_STATES cycles.
- The transaction is fixed at grant. Master changes or withdrawal after grant are ignored, and the access still completes with a ready pulse.
- Never: both ready outputs high together; both SRAM strobes high together; any strobe outside ISSUE.
- A wait counter of 4 bits covers WAIT_STATES up to 15.

Decomposition:
- Package rv32_mem_responder_pkg holds:
  - the FSM state enum (IDLE, WAIT, ISSUE, RESP);
  - the owner enum (OWNER_INSTR, OWNER_DATA);
  - the op enum (OP_READ, OP_WRITE);
  - the wait-counter width constant.
- One natural sub-module, rv32_mem_rr_arbiter: two requests plus last-served in, grant one-hot out; purely combinational.
- The bench uses a behavioural single-port SRAM model with 1-cycle read latency (not part of the RTL).

Test Plan:
- Single fetch: WAIT_STATES=0, SRAM[0x10]=0xDEADBEEF, instr_read with address 0x40 at cycle 5 -> sram_read_out at 6, instr_ready_out=1 with value 0xDEADBEEF at 7 only.
- Masked store then load: data_write to 0x80, mask 4'b0011, value 0x12345678 over word 0xAABBCCDD -> load returns 0xAABB5678; data_ready pulses once per access.
- Contention: both masters request every cycle for 20 cycles -> grants alternate data, instr, data, ...; never both readies; no master waits more than 2 accesses.
- Wait states: WAIT_STATES=3, single load at cycle 0 -> ready at cycle 5; strobe exactly at cycle 4.
- Withdrawal: data_write dropped the cycle after grant, address changed to 0x100 -> write still lands at the latched 0x80, data_ready still pulses.
- Reset mid-op: reset asserted in WAIT -> no strobe and no ready afterwards; state IDLE; a fresh fetch after release completes with nominal latency.
